montgomery_multiplier_param: RTL

- Parametrised radix-2, bit-serial Montgomery modular multiplier. Computes S = A·B·2^-WIDTH mod M.
- Successor to the fixed 16-bit multiplier. Adds a configurable width, synchronous reset, busy/done/err handshake, operand latching and odd-modulus checking.
- Sits under the RSA modular-exponentiation controller, which issues square and multiply operations through go/done.

---
 rtl/montgomery_multiplier_param.sv | 122 ++++++++++++
 1 files changed

// File: rtl/montgomery_multiplier_param.sv
// Parametrised radix-2 bit-serial Montgomery multiplier: S = A*B*2^-WIDTH mod M.
// One iteration per cycle in RUN, one conditional subtraction in FIX, then a one-cycle done pulse.
module montgomery_multiplier_param #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] M,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] S
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH+1:0] p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [WIDTH+1:0] t_sum;
  logic [WIDTH+1:0] u_sum;
  logic [WIDTH-1:0] p_minus_m;
  logic             p_ge_m;

  // P < 2M and B < M keep t + M below 4M, so WIDTH+2 bits never overflow.
  always_comb begin
    t_sum     = p_q + (a_q[0] ? {2'b00, b_q} : '0);
    u_sum     = t_sum + (t_sum[0] ? {2'b00, m_q} : '0);
    p_ge_m    = (p_q >= {2'b00, m_q});
    p_minus_m = p_q[WIDTH-1:0] - m_q;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    s_d     = s_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          a_d   = A;
          b_d   = B;
          m_d   = M;
          p_d   = '0;
          cnt_d = '0;
          if (!M[0]) begin
            err_d   = 1'b1;
            s_d     = '0;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // The multiplicand is consumed LSB first by shifting the latched copy.
        a_d   = a_q >> 1;
        p_d   = u_sum >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        s_d     = p_ge_m ? p_minus_m : p_q[WIDTH-1:0];
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      s_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      s_q     <= s_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // An even-modulus rejection jumps straight to DONE and never shows busy.
  always_comb begin
    done = (state_q == DONE);
    err  = done && err_q;
    busy = (state_q == RUN) || (state_q == FIX) || ((state_q == DONE) && !err_q);
    S    = s_q;
  end

endmodule
